// File: rtl/token_sched_pkg.sv
// Shared constants and types for the token multiplier scheduler.
package token_sched_pkg;

    localparam int unsigned N_DEF     = 4;
    localparam int unsigned MULT_DEF  = 2;
    localparam int unsigned CNT_W_DEF = 4;
    localparam int unsigned CNT_MAX   = (1 << CNT_W_DEF) - 1;

    typedef logic [$clog2(N_DEF)-1:0] id_t;

    function automatic int unsigned cnt_max(input int unsigned w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr, wrapping, as one-hot and index.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IdW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IdW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IdW-1:0] idx_o,
    output logic           valid_o
);

    logic [IdW:0]   pos_w;
    logic [IdW-1:0] pos;
    logic           found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos_w = '0;
        pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // Extra bit keeps ptr+k from aliasing before the modulo-N wrap.
            pos_w = {1'b0, ptr_i} + (IdW + 1)'(k);
            if (pos_w >= (IdW + 1)'(N)) begin
                pos_w = pos_w - (IdW + 1)'(N);
            end
            pos = pos_w[IdW-1:0];
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/token_mult_scheduler.sv
// Multiplies per-channel input tokens into credits and drains them round-robin onto one
// serial token output under downstream backpressure.
module token_mult_scheduler
    import token_sched_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned MULT  = MULT_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    localparam int unsigned IdW  = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   a,
    input  logic           ready,
    output logic           b,
    output logic [IdW-1:0] b_id,
    output logic [N-1:0]   overflow
);

    localparam logic [CNT_W:0] MaxW  = (CNT_W + 1)'(cnt_max(CNT_W));
    localparam logic [CNT_W:0] MultW = (CNT_W + 1)'(MULT);

    logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]            ovf_q, ovf_d;
    logic [N-1:0]            nz, gnt;
    logic [IdW-1:0]          ptr_q, ptr_d, idx;
    logic                    any, consume;
    logic [CNT_W:0]          sum;

    always_comb begin
        nz = '0;
        for (int unsigned i = 0; i < N; i++) begin
            nz[i] = (cnt_q[i] != '0);
        end
    end

    rr_arbiter #(
        .N(N)
    ) u_arb (
        .req_i  (nz),
        .ptr_i  (ptr_q),
        .gnt_o  (gnt),
        .idx_o  (idx),
        .valid_o(any)
    );

    assign consume = any & ready;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        sum   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // Wide sum so saturation sees the true total; excess credits are dropped.
            sum = {1'b0, cnt_q[i]} + (a[i] ? MultW : '0)
                  - {{CNT_W{1'b0}}, consume & gnt[i]};
            if (sum > MaxW) begin
                cnt_d[i] = MaxW[CNT_W-1:0];
                ovf_d[i] = 1'b1;
            end else begin
                cnt_d[i] = sum[CNT_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (consume) begin
            ptr_d = (idx == IdW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= '0;
            ptr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            ptr_q <= ptr_d;
        end
    end

    assign b        = any;
    assign b_id     = any ? idx : '0;
    assign overflow = ovf_q;

endmodule
